// File: rtl/fpu_norm_arbiter_if.sv
// Request, encoder and result bundle for the shared FPU normaliser.
// slave is the arbiter side; master is the requester/encoder/downstream side.
interface fpu_norm_arbiter_if #(
  parameter int unsigned WIDTH     = 106,
  parameter int unsigned WIDTH_LOG = 7,
  parameter int unsigned EXP_W     = 11
);
  logic                 req0_valid;
  logic [WIDTH-1:0]     req0_mant;
  logic [EXP_W-1:0]     req0_exp;
  logic                 req0_ready;
  logic                 req1_valid;
  logic [WIDTH-1:0]     req1_mant;
  logic [EXP_W-1:0]     req1_exp;
  logic                 req1_ready;
  logic [WIDTH-1:0]     enc_value;
  logic [WIDTH_LOG-1:0] enc_msb;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_mant;
  logic [EXP_W-1:0]     out_exp;
  logic                 out_zero;
  logic                 out_uflow;
  logic                 out_src;
  logic                 busy;

  modport slave (
    input  req0_valid, req0_mant, req0_exp, req1_valid, req1_mant, req1_exp,
    input  enc_msb, out_ready,
    output req0_ready, req1_ready, enc_value,
    output out_valid, out_mant, out_exp, out_zero, out_uflow, out_src, busy
  );

  modport master (
    output req0_valid, req0_mant, req0_exp, req1_valid, req1_mant, req1_exp,
    output enc_msb, out_ready,
    input  req0_ready, req1_ready, enc_value,
    input  out_valid, out_mant, out_exp, out_zero, out_uflow, out_src, busy
  );
endinterface

// File: rtl/fpu_norm_arbiter.sv
// Round-robin arbiter sharing one leading-one encoder and a log-stage
// iterative left-shift normaliser between the multiplier and adder results.
module fpu_norm_arbiter #(
  parameter int unsigned WIDTH     = 106,
  parameter int unsigned WIDTH_LOG = 7,
  parameter int unsigned EXP_W     = 11
) (
  input logic               clk,
  input logic               rst,
  fpu_norm_arbiter_if.slave bus
);
  localparam int unsigned K_W = (WIDTH_LOG > 1) ? $clog2(WIDTH_LOG) : 1;

  typedef enum logic [1:0] {IDLE, ENC, SHIFT, DONE} state_t;

  state_t               state_q, state_d;
  logic                 rr_q, rr_d;
  logic [WIDTH-1:0]     mant_q, mant_d;
  logic [EXP_W-1:0]     exp_q, exp_d;
  logic                 src_q, src_d;
  logic                 zero_q, zero_d;
  logic                 uflow_q, uflow_d;
  logic [WIDTH_LOG-1:0] shamt_q, shamt_d;
  logic [K_W-1:0]       k_q, k_d;
  logic                 valid_q, valid_d;
  logic [WIDTH-1:0]     enc_q, enc_d;
  logic                 grant0_c, grant1_c;
  logic [EXP_W-1:0]     lz_c, shamt_c;
  logic                 uflow_c;

  // Next-state and datapath; the out_* registers double as working registers
  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    mant_d   = mant_q;
    exp_d    = exp_q;
    src_d    = src_q;
    zero_d   = zero_q;
    uflow_d  = uflow_q;
    shamt_d  = shamt_q;
    k_d      = k_q;
    valid_d  = valid_q;
    enc_d    = '0;
    grant0_c = 1'b0;
    grant1_c = 1'b0;
    lz_c     = EXP_W'(WIDTH - 1) - EXP_W'(bus.enc_msb);
    uflow_c  = lz_c > exp_q;
    shamt_c  = uflow_c ? exp_q : lz_c;

    case (state_q)
      IDLE: begin
        // rr_q set means req1 wins a tie
        grant1_c = bus.req1_valid & (~bus.req0_valid | rr_q);
        grant0_c = bus.req0_valid & ~grant1_c;
        if (grant0_c | grant1_c) begin
          mant_d  = grant1_c ? bus.req1_mant : bus.req0_mant;
          exp_d   = grant1_c ? bus.req1_exp : bus.req0_exp;
          src_d   = grant1_c;
          rr_d    = ~grant1_c;
          zero_d  = 1'b0;
          uflow_d = 1'b0;
          enc_d   = mant_d;
          state_d = ENC;
        end
      end
      ENC: begin
        if (mant_q == '0) begin
          zero_d  = 1'b1;
          uflow_d = 1'b0;
          exp_d   = '0;
          valid_d = 1'b1;
          state_d = DONE;
        end else begin
          // Clamp the shift so the biased exponent bottoms out at zero
          shamt_d = WIDTH_LOG'(shamt_c);
          uflow_d = uflow_c;
          exp_d   = exp_q - shamt_c;
          k_d     = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (shamt_q[k_q]) mant_d = mant_q << (32'd1 << k_q);
        k_d = k_q + K_W'(1);
        if (k_q == K_W'(WIDTH_LOG - 1)) begin
          valid_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      mant_q  <= '0;
      exp_q   <= '0;
      src_q   <= 1'b0;
      zero_q  <= 1'b0;
      uflow_q <= 1'b0;
      shamt_q <= '0;
      k_q     <= '0;
      valid_q <= 1'b0;
      enc_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      mant_q  <= mant_d;
      exp_q   <= exp_d;
      src_q   <= src_d;
      zero_q  <= zero_d;
      uflow_q <= uflow_d;
      shamt_q <= shamt_d;
      k_q     <= k_d;
      valid_q <= valid_d;
      enc_q   <= enc_d;
    end
  end

  assign bus.req0_ready = grant0_c;
  assign bus.req1_ready = grant1_c;
  assign bus.enc_value  = enc_q;
  assign bus.out_valid  = valid_q;
  assign bus.out_mant   = mant_q;
  assign bus.out_exp    = exp_q;
  assign bus.out_zero   = zero_q;
  assign bus.out_uflow  = uflow_q;
  assign bus.out_src    = src_q;
  assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_fpu_norm_arbiter.sv
// Directed bench for fpu_norm_arbiter: grant order, latency, clamping,
// zero handling, backpressure and mid-operation reset.
module tb_fpu_norm_arbiter;
  localparam int unsigned W  = 106;
  localparam int unsigned WL = 7;
  localparam int unsigned E  = 11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  fpu_norm_arbiter_if #(.WIDTH(W), .WIDTH_LOG(WL), .EXP_W(E)) bus ();

  fpu_norm_arbiter #(.WIDTH(W), .WIDTH_LOG(WL), .EXP_W(E)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference leading-one encoder
  logic [WL-1:0] msb_c;
  always_comb begin
    msb_c = '0;
    for (int i = 0; i < int'(W); i++) if (bus.enc_value[i]) msb_c = WL'(i);
  end
  assign bus.enc_msb = msb_c;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(inout int lat);
    while (!bus.out_valid && lat < 40) begin
      step();
      lat++;
    end
  endtask

  // Present one request from a single source; returns latency and the encoder input seen in ENC
  task automatic send(input logic s, input logic [W-1:0] m, input logic [E-1:0] e,
                      output int lat, output logic [W-1:0] enc_seen);
    if (s) begin
      bus.req1_valid = 1'b1; bus.req1_mant = m; bus.req1_exp = e;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_mant = m; bus.req0_exp = e;
    end
    #1;
    chk("grant", 128'({bus.req1_ready, bus.req0_ready}), s ? 128'd2 : 128'd1);
    step();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    enc_seen = bus.enc_value;
    lat = 1;
    wait_out(lat);
  endtask

  initial begin
    int lat;
    logic [W-1:0] enc_seen;
    logic [W-1:0] m5;
    bus.req0_valid = 1'b0; bus.req0_mant = '0; bus.req0_exp = '0;
    bus.req1_valid = 1'b0; bus.req1_mant = '0; bus.req1_exp = '0;
    bus.out_ready  = 1'b1;
    step(); step();
    rst = 1'b0;

    // Reset state
    chk("rst_valid", 128'(bus.out_valid), 128'd0);
    chk("rst_busy", 128'(bus.busy), 128'd0);
    chk("rst_mant", 128'(bus.out_mant), 128'd0);
    chk("rst_enc", 128'(bus.enc_value), 128'd0);
    chk("rst_ready", 128'({bus.req1_ready, bus.req0_ready}), 128'd0);

    // 1: basic normalise from req0
    send(1'b0, W'(1) << 100, E'(200), lat, enc_seen);
    chk("t1_enc", 128'(enc_seen), 128'(W'(1) << 100));
    chk("t1_lat", 128'(lat), 128'd9);
    chk("t1_mant", 128'(bus.out_mant), 128'(W'(1) << 105));
    chk("t1_exp", 128'(bus.out_exp), 128'd195);
    chk("t1_flags", 128'({bus.out_src, bus.out_zero, bus.out_uflow}), 128'd0);
    step();
    chk("t1_drop", 128'({bus.out_valid, bus.busy}), 128'd0);

    // 2: zero mantissa from req1
    send(1'b1, '0, E'(77), lat, enc_seen);
    chk("t2_lat", 128'(lat), 128'd2);
    chk("t2_out", 128'({bus.out_src, bus.out_zero, bus.out_uflow, bus.out_exp, bus.out_mant}),
        {8'd0, 3'b110, 117'd0});
    step();

    // 3: simultaneous requests after reset, req0 first then req1
    rst = 1'b1; step(); rst = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_mant = W'(1) << 104; bus.req0_exp = E'(3);
    bus.req1_valid = 1'b1; bus.req1_mant = W'(1) << 50;  bus.req1_exp = E'(100);
    #1;
    chk("t3_grant0", 128'({bus.req1_ready, bus.req0_ready}), 128'd1);
    step();
    bus.req0_valid = 1'b0;
    lat = 1;
    wait_out(lat);
    chk("t3_lat0", 128'(lat), 128'd9);
    chk("t3_res0", 128'({bus.out_src, bus.out_exp, bus.out_mant}), 128'({1'b0, E'(2), W'(1) << 105}));
    chk("t3_wait1", 128'(bus.req1_ready), 128'd0);
    step();
    chk("t3_grant1", 128'({bus.req1_ready, bus.req0_ready}), 128'd2);
    step();
    bus.req1_valid = 1'b0;
    lat = 1;
    wait_out(lat);
    chk("t3_lat1", 128'(lat), 128'd9);
    chk("t3_res1", 128'({bus.out_src, bus.out_uflow, bus.out_exp, bus.out_mant}),
        128'({1'b1, 1'b0, E'(45), W'(1) << 105}));
    step();

    // 4: shift clamped by exponent
    send(1'b0, W'(1), E'(10), lat, enc_seen);
    chk("t4_lat", 128'(lat), 128'd9);
    chk("t4_res", 128'({bus.out_zero, bus.out_uflow, bus.out_exp, bus.out_mant}),
        128'({1'b0, 1'b1, E'(0), W'(1) << 10}));
    step();

    // 5: already normalised, then held under backpressure with both requesters waiting
    bus.out_ready = 1'b0;
    m5 = (W'(1) << 105) | W'(1);
    send(1'b1, m5, E'(5), lat, enc_seen);
    chk("t5_lat", 128'(lat), 128'd9);
    chk("t5_res", 128'({bus.out_src, bus.out_uflow, bus.out_exp, bus.out_mant}),
        128'({1'b1, 1'b0, E'(5), m5}));
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("t5_hold", 128'({bus.out_valid, bus.req1_ready, bus.req0_ready, bus.out_exp, bus.out_mant}),
          128'({3'b100, E'(5), m5}));
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.out_ready  = 1'b1;
    step();
    chk("t5_done", 128'({bus.out_valid, bus.busy}), 128'd0);
    chk("t5_keep", 128'({bus.out_exp, bus.out_mant}), 128'({E'(5), m5}));

    // 6: reset while shifting drops the operation
    bus.req0_valid = 1'b1; bus.req0_mant = W'(1) << 100; bus.req0_exp = E'(200);
    step();
    bus.req0_valid = 1'b0;
    step(); step(); step();
    chk("t6_busy", 128'(bus.busy), 128'd1);
    rst = 1'b1; step(); rst = 1'b0;
    chk("t6_rst", 128'({bus.out_valid, bus.busy}), 128'd0);
    for (int i = 0; i < 10; i++) step();
    chk("t6_nodrop", 128'(bus.out_valid), 128'd0);
    send(1'b0, W'(1) << 100, E'(200), lat, enc_seen);
    chk("t6_lat", 128'(lat), 128'd9);
    chk("t6_res", 128'({bus.out_src, bus.out_uflow, bus.out_exp, bus.out_mant}),
        128'({1'b0, 1'b0, E'(195), W'(1) << 105}));
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule
